serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half-adder stages plus a carry flop)
// reused for WIDTH cycles, LSB first. Define SERIAL_ADD_SUB_EN to add a 'sub' port for a - b.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_sha;
   logic [WIDTH-1:0] r_shb;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_resultNext;
   logic [CW-1:0]    r_count;
   logic             r_carry;
   logic             r_cout;
   logic             r_outValid;
   logic             w_p;
   logic             w_g;
   logic             w_sum;
   logic             w_carryNext;
   logic             w_lastBit;
   logic             w_subSel;

`ifdef SERIAL_ADD_SUB_EN
   assign w_subSel = sub;
`else
   assign w_subSel = 1'b0;
`endif

   assign w_p         = r_sha[0] ^ r_shb[0];
   assign w_g         = r_sha[0] & r_shb[0];
   assign w_sum       = w_p ^ r_carry;
   assign w_carryNext = w_g | (w_p & r_carry);
   assign w_lastBit   = (r_count == CW'(WIDTH - 1));

   // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_single
         assign w_resultNext = w_sum;
      end else begin : g_multi
         assign w_resultNext = {w_sum, r_result[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_nextState = SHIFT;
         SHIFT:   if (w_lastBit) w_nextState = DONE;
         DONE:    if (out_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Subtraction reuses the adder as a + ~b + 1, so the carry-out doubles as "no borrow".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sha      <= '0;
         r_shb      <= '0;
         r_carry    <= 1'b0;
         r_count    <= '0;
         r_result   <= '0;
         r_cout     <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         r_outValid <= (w_nextState == DONE);
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sha   <= a;
                  r_shb   <= w_subSel ? ~b : b;
                  r_carry <= w_subSel;
                  r_count <= '0;
               end
            end
            SHIFT: begin
               r_sha    <= r_sha >> 1;
               r_shb    <= r_shb >> 1;
               r_carry  <= w_carryNext;
               r_result <= w_resultNext;
               r_count  <= r_count + CW'(1);
               if (w_lastBit) begin
                  r_cout <= w_carryNext;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = r_outValid;
   assign result    = r_result;
   assign cout      = r_cout;

endmodule
